wdt_heartbeat_gen: RTL

Heartbeat generator for the watchdog timer: it produces the `kick` pulses that the watchdog consumes on their rising edge. A kick is issued once per period only if every monitored task has reported alive during that period. If any task stays silent, or the shutdown controller forces a stop, kicks are withheld so the watchdog times out. It sits between the task-level alive strobes and the watchdog's `kick` input.

---
 rtl/wdt_heartbeat_gen.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wdt_heartbeat_gen.sv
// ---------------------------------------------------------------------------
// wdt_heartbeat_gen
//
// Heartbeat generator for the watchdog timer. Once per kick period it checks
// that every monitored task has strobed its alive bit at least once during
// that period. If they all have, it issues a KICK_HIGH_CYCLES-long pulse on
// o_kick. If any task stayed silent, or the shutdown controller requested a
// stop, it withholds kicks and parks in STALLED so that the watchdog expires.
//
// Ports:
//   i_clk            system clock
//   i_rst            asynchronous, active-high reset
//   i_enable         level, 1 = generator running; 0 returns to IDLE
//   i_force_stop     stop request from the shutdown controller (RUN only)
//   i_task_alive     per-task alive strobes, any high cycle counts
//   o_kick           registered heartbeat pulse to the watchdog
//   o_kick_count     kicks issued since leaving IDLE, wraps at 16 bits
//   o_missing_tasks  tasks that failed the check that caused the stall
//   o_stalled        high while in STALLED
//   o_forced         high when the stall was caused by i_force_stop
// ---------------------------------------------------------------------------
module wdt_heartbeat_gen #(
    parameter int CLK_HZ           = 24000000,
    parameter int KICK_PERIOD_MS   = 100,
    parameter int KICK_HIGH_CYCLES = 4,
    parameter int NUM_TASKS        = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_force_stop,
    input  logic [NUM_TASKS-1:0] i_task_alive,
    output logic                 o_kick,
    output logic [15:0]          o_kick_count,
    output logic [NUM_TASKS-1:0] o_missing_tasks,
    output logic                 o_stalled,
    output logic                 o_forced
);

    localparam longint PERIOD   = (longint'(CLK_HZ) / 1000) * longint'(KICK_PERIOD_MS);
    localparam logic [24:0] CNT_LAST = 25'(PERIOD - 1);
    localparam logic [24:0] KICK_LEN = 25'(KICK_HIGH_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STALLED = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic                  r_enableQ;
    logic [24:0]           r_cnt;
    logic [24:0]           w_cntNext;
    logic [NUM_TASKS-1:0]  r_alive;
    logic [NUM_TASKS-1:0]  w_aliveNext;
    logic                  r_kick;
    logic                  w_kickNext;
    logic [15:0]           r_kickCount;
    logic [15:0]           w_kickCountNext;
    logic [NUM_TASKS-1:0]  r_missing;
    logic [NUM_TASKS-1:0]  w_missingNext;
    logic                  r_stalled;
    logic                  w_stalledNext;
    logic                  r_forced;
    logic                  w_forcedNext;
    logic [NUM_TASKS-1:0]  w_eff;
    logic                  w_check;

    // Delayed copy of enable. Leaving IDLE waits for enable to be seen on two
    // consecutive edges, so enable sampled at edge E gives RUN with cnt=0
    // after edge E+1 and the first kick at edge E+1+P. Dropping enable still
    // acts on the very next edge because it uses the live input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_enableQ <= 1'b0;
        end else begin
            r_enableQ <= i_enable;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and next-output logic. Every output is computed here one
    // cycle ahead and registered below, so nothing combinational reaches a
    // port. Priority is enable=0, then force_stop, then the check result.
    always_comb begin
        w_stateNext     = r_state;
        w_cntNext       = r_cnt;
        w_aliveNext     = r_alive;
        w_kickNext      = 1'b0;
        w_kickCountNext = r_kickCount;
        w_missingNext   = r_missing;
        w_stalledNext   = r_stalled;
        w_forcedNext    = r_forced;

        // Strobes arriving on the check cycle itself still count.
        w_eff   = r_alive | i_task_alive;
        w_check = (r_cnt == CNT_LAST);

        if (!i_enable) begin
            w_stateNext     = IDLE;
            w_cntNext       = '0;
            w_aliveNext     = '0;
            w_kickCountNext = '0;
            w_missingNext   = '0;
            w_stalledNext   = 1'b0;
            w_forcedNext    = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_cntNext       = '0;
                    w_aliveNext     = '0;
                    w_kickCountNext = '0;
                    w_missingNext   = '0;
                    w_stalledNext   = 1'b0;
                    w_forcedNext    = 1'b0;
                    if (r_enableQ) begin
                        w_stateNext = RUN;
                    end
                end

                RUN: begin
                    if (i_force_stop) begin
                        w_stateNext   = STALLED;
                        w_missingNext = '0;
                        w_stalledNext = 1'b1;
                        w_forcedNext  = 1'b1;
                    end else if (w_check) begin
                        if (&w_eff) begin
                            w_cntNext       = '0;
                            w_aliveNext     = '0;
                            w_kickNext      = 1'b1;
                            w_kickCountNext = r_kickCount + 16'd1;
                        end else begin
                            w_stateNext   = STALLED;
                            w_missingNext = ~w_eff;
                            w_stalledNext = 1'b1;
                        end
                    end else begin
                        w_cntNext   = r_cnt + 25'd1;
                        w_aliveNext = w_eff;
                        // A pulse only ever starts at cnt=0, so it stays high
                        // while the upcoming count is still inside the pulse.
                        w_kickNext  = r_kick && ((r_cnt + 25'd1) < KICK_LEN);
                    end
                end

                STALLED: begin
                    w_stateNext = STALLED;
                end

                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_alive     <= '0;
            r_kick      <= 1'b0;
            r_kickCount <= '0;
            r_missing   <= '0;
            r_stalled   <= 1'b0;
            r_forced    <= 1'b0;
        end else begin
            r_cnt       <= w_cntNext;
            r_alive     <= w_aliveNext;
            r_kick      <= w_kickNext;
            r_kickCount <= w_kickCountNext;
            r_missing   <= w_missingNext;
            r_stalled   <= w_stalledNext;
            r_forced    <= w_forcedNext;
        end
    end

    assign o_kick          = r_kick;
    assign o_kick_count    = r_kickCount;
    assign o_missing_tasks = r_missing;
    assign o_stalled       = r_stalled;
    assign o_forced        = r_forced;

endmodule
